// File: rtl/wb_pipe_reg_pkg.sv
// Shared definitions for the WB pipeline register: reset/write polarity
// constants, named stall-vector bit positions and the per-cycle action type.
// Optional HI/LO path is enabled by defining WB_HILO_EN.
package wb_pipe_reg_pkg;

  localparam logic        RstEnable    = 1'b0;
  localparam logic        RstDisable   = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg      = 5'd0;

  // Bit positions in the control unit's stall vector, one per stage.
  localparam int unsigned StallPc  = 0;
  localparam int unsigned StallIf  = 1;
  localparam int unsigned StallId  = 2;
  localparam int unsigned StallEx  = 3;
  localparam int unsigned StallMem = 4;
  localparam int unsigned StallWb  = 5;

  // What the register does on the next rising edge.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } wb_act_e;

  // Flush beats everything; a stalled upstream feeding a running stage
  // inserts a bubble; a stalled own stage holds; otherwise load.
  function automatic wb_act_e decode_action(input logic flush,
                                            input logic stall_prev,
                                            input logic stall_self);
    if (flush)                        return ACT_BUBBLE;
    else if (stall_prev && !stall_self) return ACT_BUBBLE;
    else if (stall_self)              return ACT_HOLD;
    else                              return ACT_LOAD;
  endfunction

endpackage

// File: rtl/wb_chan_reg.sv
// One register-write channel of the WB pipeline register: write enable,
// destination address and data, with load / bubble / hold control.
module wb_chan_reg
  import wb_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  wb_act_e           act,
  input  logic              in_wd,
  input  logic [REG_AW-1:0] in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_wd,
  output logic [REG_AW-1:0] out_wreg,
  output logic [DATA_W-1:0] out_wdata
);

  logic              wd_q,    wd_d;
  logic [REG_AW-1:0] wreg_q,  wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Next-state selection from the decoded action.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    case (act)
      ACT_LOAD: begin
        wd_d    = in_wd;
        wreg_d  = in_wreg;
        wdata_d = in_wdata;
      end
      ACT_BUBBLE: begin
        wd_d    = WriteDisable;
        wreg_d  = '0;
        wdata_d = '0;
      end
      default: ;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst == RstEnable) begin
      wd_q    <= WriteDisable;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign out_wd    = wd_q;
  assign out_wreg  = wreg_q;
  assign out_wdata = wdata_q;

endmodule

// File: rtl/wb_pipe_reg.sv
// EX/MEM-to-WB pipeline register for a multi-issue core. Drops r0 writes,
// lets the youngest channel win same-address collisions, flags resolved
// collisions and counts retired instructions.
// Defining WB_HILO_EN adds a registered HI/LO write path.
module wb_pipe_reg
  import wb_pipe_reg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int NUM_CH    = 2,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 4,
  parameter int CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        ex_valid,
  input  logic [NUM_CH-1:0]        ex_wd,
  input  logic [NUM_CH*REG_AW-1:0] ex_wreg,
  input  logic [NUM_CH*DATA_W-1:0] ex_wdata,
`ifdef WB_HILO_EN
  input  logic                     ex_whilo,
  input  logic [DATA_W-1:0]        ex_hi,
  input  logic [DATA_W-1:0]        ex_lo,
  output logic                     wb_whilo,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
`endif
  output logic [NUM_CH-1:0]        wb_wd,
  output logic [NUM_CH*REG_AW-1:0] wb_wreg,
  output logic [NUM_CH*DATA_W-1:0] wb_wdata,
  output logic                     wb_conflict,
  output logic [CNT_W-1:0]         wb_retire_cnt
);

  wb_act_e           act;
  logic [NUM_CH-1:0] we;
  logic [NUM_CH-1:0] keep;
  logic              collide;
  logic [CNT_W-1:0]  cnt_inc;
  logic              conflict_q, conflict_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              stall_unused;

  // Only two stall bits matter here; fold the rest into a named sink.
  assign stall_unused = ^stall;

  assign act = decode_action(flush, stall[STAGE_IDX-1], stall[STAGE_IDX]);

  // Drop r0 writes, then clear any write shadowed by a younger channel.
  always_comb begin
    we      = '0;
    keep    = '0;
    collide = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      we[i] = ex_wd[i] && (ex_wreg[i*REG_AW +: REG_AW] != '0);
    end
    keep = we;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = i + 1; j < NUM_CH; j++) begin
        if (we[i] && we[j] &&
            (ex_wreg[j*REG_AW +: REG_AW] == ex_wreg[i*REG_AW +: REG_AW])) begin
          keep[i] = 1'b0;
          collide = 1'b1;
        end
      end
    end
  end

  // Per-channel output registers; cleared channels load zeros.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    wb_chan_reg #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .act       (act),
      .in_wd     (keep[g]),
      .in_wreg   (keep[g] ? ex_wreg[g*REG_AW +: REG_AW] : '0),
      .in_wdata  (keep[g] ? ex_wdata[g*DATA_W +: DATA_W] : '0),
      .out_wd    (wb_wd[g]),
      .out_wreg  (wb_wreg[g*REG_AW +: REG_AW]),
      .out_wdata (wb_wdata[g*DATA_W +: DATA_W])
    );
  end

  // Conflict flag and retire counter next state; counter wraps modulo 2^CNT_W.
  always_comb begin
    cnt_inc    = '0;
    conflict_d = conflict_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_inc = cnt_inc + CNT_W'(ex_valid[i]);
    end
    case (act)
      ACT_LOAD: begin
        conflict_d = collide;
        cnt_d      = cnt_q + cnt_inc;
      end
      ACT_BUBBLE: conflict_d = 1'b0;
      default: ;
    endcase
  end

  // Conflict flag and retire counter registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wb_conflict   = conflict_q;
  assign wb_retire_cnt = cnt_q;

`ifdef WB_HILO_EN
  logic              whilo_q, whilo_d;
  logic [DATA_W-1:0] hi_q,    hi_d;
  logic [DATA_W-1:0] lo_q,    lo_d;

  // HI/LO next state; values are zeroed when no HI/LO write is loaded.
  always_comb begin
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (act)
      ACT_LOAD: begin
        whilo_d = ex_whilo;
        hi_d    = ex_whilo ? ex_hi : '0;
        lo_d    = ex_whilo ? ex_lo : '0;
      end
      ACT_BUBBLE: begin
        whilo_d = WriteDisable;
        hi_d    = '0;
        lo_d    = '0;
      end
      default: ;
    endcase
  end

  // HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      whilo_q <= WriteDisable;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign wb_whilo = whilo_q;
  assign wb_hi    = hi_q;
  assign wb_lo    = lo_q;
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Self-checking bench for wb_pipe_reg: directed scenarios plus randomized
// traffic against a behavioural model. HI/LO checks compile in when
// WB_HILO_EN is defined. A narrow counter makes the wrap reachable.
module tb_wb_pipe_reg;

  localparam int DATA_W    = 32;
  localparam int REG_AW    = 5;
  localparam int NUM_CH    = 2;
  localparam int STALL_W   = 6;
  localparam int STAGE_IDX = 4;
  localparam int CNT_W     = 6;
  localparam int CNT_MOD   = 1 << CNT_W;
`ifdef WB_HILO_EN
  localparam int HL_W = 1 + 2 * DATA_W;
`else
  localparam int HL_W = 0;
`endif
  localparam int BUS_W = NUM_CH + NUM_CH*REG_AW + NUM_CH*DATA_W + 1 + CNT_W + HL_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [STALL_W-1:0]       stall;
  logic                     flush;
  logic [NUM_CH-1:0]        ex_valid;
  logic [NUM_CH-1:0]        ex_wd;
  logic [NUM_CH*REG_AW-1:0] ex_wreg;
  logic [NUM_CH*DATA_W-1:0] ex_wdata;
  logic [NUM_CH-1:0]        wb_wd;
  logic [NUM_CH*REG_AW-1:0] wb_wreg;
  logic [NUM_CH*DATA_W-1:0] wb_wdata;
  logic                     wb_conflict;
  logic [CNT_W-1:0]         wb_retire_cnt;
`ifdef WB_HILO_EN
  logic                     ex_whilo;
  logic [DATA_W-1:0]        ex_hi, ex_lo;
  logic                     wb_whilo;
  logic [DATA_W-1:0]        wb_hi, wb_lo;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  logic [NUM_CH-1:0]        m_wd;
  logic [NUM_CH*REG_AW-1:0] m_wreg;
  logic [NUM_CH*DATA_W-1:0] m_wdata;
  logic                     m_conf;
  int                       m_cnt;
`ifdef WB_HILO_EN
  logic                     m_whilo;
  logic [DATA_W-1:0]        m_hi, m_lo;
`endif

  always #5 clk = ~clk;

  wb_pipe_reg #(
    .DATA_W    (DATA_W),
    .REG_AW    (REG_AW),
    .NUM_CH    (NUM_CH),
    .STALL_W   (STALL_W),
    .STAGE_IDX (STAGE_IDX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_wd         (ex_wd),
    .ex_wreg       (ex_wreg),
    .ex_wdata      (ex_wdata),
`ifdef WB_HILO_EN
    .ex_whilo      (ex_whilo),
    .ex_hi         (ex_hi),
    .ex_lo         (ex_lo),
    .wb_whilo      (wb_whilo),
    .wb_hi         (wb_hi),
    .wb_lo         (wb_lo),
`endif
    .wb_wd         (wb_wd),
    .wb_wreg       (wb_wreg),
    .wb_wdata      (wb_wdata),
    .wb_conflict   (wb_conflict),
    .wb_retire_cnt (wb_retire_cnt)
  );

  function automatic logic [BUS_W-1:0] dut_bus();
    return {wb_wd, wb_wreg, wb_wdata, wb_conflict, wb_retire_cnt
`ifdef WB_HILO_EN
            , wb_whilo, wb_hi, wb_lo
`endif
           };
  endfunction

  function automatic logic [BUS_W-1:0] model_bus();
    logic [CNT_W-1:0] c;
    c = CNT_W'(m_cnt);
    return {m_wd, m_wreg, m_wdata, m_conf, c
`ifdef WB_HILO_EN
            , m_whilo, m_hi, m_lo
`endif
           };
  endfunction

  task automatic model_bubble();
    m_wd = '0; m_wreg = '0; m_wdata = '0; m_conf = 1'b0;
`ifdef WB_HILO_EN
    m_whilo = 1'b0; m_hi = '0; m_lo = '0;
`endif
  endtask

  // Apply the rules to the inputs present at the edge just taken.
  task automatic model_step();
    bit [(1<<REG_AW)-1:0] claimed;
    int a;
    if (rst === 1'b0) begin
      model_bubble();
      m_cnt = 0;
    end else if (flush || (stall[STAGE_IDX-1] && !stall[STAGE_IDX])) begin
      model_bubble();
    end else if (stall[STAGE_IDX]) begin
      // hold: nothing changes
    end else begin
      claimed = '0;
      m_conf  = 1'b0;
      // Walk youngest to oldest; an address already written by a younger
      // channel makes the older write redundant.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        a = int'(ex_wreg[i*REG_AW +: REG_AW]);
        m_wd[i] = 1'b0;
        m_wreg[i*REG_AW +: REG_AW]  = '0;
        m_wdata[i*DATA_W +: DATA_W] = '0;
        if (ex_wd[i] && a != 0) begin
          if (claimed[a]) begin
            m_conf = 1'b1;
          end else begin
            m_wd[i] = 1'b1;
            m_wreg[i*REG_AW +: REG_AW]  = ex_wreg[i*REG_AW +: REG_AW];
            m_wdata[i*DATA_W +: DATA_W] = ex_wdata[i*DATA_W +: DATA_W];
          end
          claimed[a] = 1'b1;
        end
      end
      m_cnt = (m_cnt + $countones(ex_valid)) % CNT_MOD;
`ifdef WB_HILO_EN
      m_whilo = ex_whilo;
      m_hi    = ex_whilo ? ex_hi : '0;
      m_lo    = ex_whilo ? ex_lo : '0;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic rand_inputs(input int addr_max);
    ex_valid = NUM_CH'($urandom);
    ex_wd    = NUM_CH'($urandom);
    for (int i = 0; i < NUM_CH; i++) begin
      ex_wreg[i*REG_AW +: REG_AW]  = REG_AW'($urandom_range(0, addr_max));
      ex_wdata[i*DATA_W +: DATA_W] = $urandom;
    end
`ifdef WB_HILO_EN
    ex_whilo = 1'($urandom);
    ex_hi    = $urandom;
    ex_lo    = $urandom;
`endif
  endtask

  task automatic set_ch(input int ch, input logic wd, input logic [REG_AW-1:0] r,
                        input logic [DATA_W-1:0] d);
    ex_wd[ch] = wd;
    ex_wreg[ch*REG_AW +: REG_AW]  = r;
    ex_wdata[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'($urandom); stall = STALL_W'($urandom);
    for (int k = 0; k < 2; k++) begin
      rand_inputs(31);
      tick();
      n_chk++;
      if (dut_bus() !== '0) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h want 0", k, dut_bus());
      end
    end
    rst = 1'b1; flush = 1'b0; stall = '0;
  endtask

  task automatic test_plain_load();
    ex_valid = 2'b11;
    set_ch(0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    set_ch(1, 1'b1, 5'd7, 32'h1234_5678);
    tick();
    n_chk++;
    if ({wb_wd, wb_wreg, wb_wdata, wb_conflict, wb_retire_cnt} !==
        {2'b11, 5'd7, 5'd3, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 6'd2}) begin
      n_err++;
      $display("FAIL plain_load: got wd=%b wreg=%h wdata=%h conf=%b cnt=%0d",
               wb_wd, wb_wreg, wb_wdata, wb_conflict, wb_retire_cnt);
    end
  endtask

  task automatic test_collision_r0();
    ex_valid = 2'b11;
    set_ch(0, 1'b1, 5'd9, 32'h1);
    set_ch(1, 1'b1, 5'd9, 32'h2);
    tick();
    n_chk++;
    if ({wb_wd, wb_wreg, wb_wdata, wb_conflict} !==
        {2'b10, 5'd9, 5'd0, 32'h2, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL collision: got wd=%b wreg=%h wdata=%h conf=%b",
               wb_wd, wb_wreg, wb_wdata, wb_conflict);
    end
    n_chk++;
    if (wb_retire_cnt !== CNT_W'(m_cnt)) begin
      n_err++;
      $display("FAIL collision_cnt: got %0d want %0d", wb_retire_cnt, m_cnt);
    end
    set_ch(0, 1'b1, 5'd0, 32'hAAAA_5555);
    set_ch(1, 1'b1, 5'd4, 32'h0BAD_F00D);
    ex_valid = 2'b01;
    tick();
    n_chk++;
    if ({wb_wd, wb_wreg, wb_wdata, wb_conflict} !==
        {2'b10, 5'd4, 5'd0, 32'h0BAD_F00D, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL r0_drop: got wd=%b wreg=%h wdata=%h conf=%b",
               wb_wd, wb_wreg, wb_wdata, wb_conflict);
    end
  endtask

  task automatic test_stall();
    stall = 6'b011111;
    for (int k = 0; k < 3; k++) begin
      rand_inputs(31);
      ex_valid = 2'b11;
      tick();
      n_chk++;
      if (dut_bus() !== model_bus()) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got %h want %h", k, dut_bus(), model_bus());
      end
    end
    stall = '0;
  endtask

  task automatic test_bubble();
    rand_inputs(31);
    tick();
    stall = 6'b001111;
    rand_inputs(31);
    ex_valid = 2'b11;
    tick();
    n_chk++;
    if ({wb_wd, wb_wreg, wb_wdata, wb_conflict} !== '0 ||
        wb_retire_cnt !== CNT_W'(m_cnt)) begin
      n_err++;
      $display("FAIL bubble: got %h want %h", dut_bus(), model_bus());
    end
    stall = '0;
  endtask

  task automatic test_flush();
    ex_valid = 2'b11;
    set_ch(0, 1'b1, 5'd1, 32'h11);
    set_ch(1, 1'b1, 5'd1, 32'h22);
    tick();
    flush = 1'b1; stall = 6'b001111;
    tick();
    n_chk++;
    if ({wb_wd, wb_conflict} !== 3'b000 || dut_bus() !== model_bus()) begin
      n_err++;
      $display("FAIL flush_bubble: got %h want %h", dut_bus(), model_bus());
    end
    ex_wreg = 10'h0a2;
    tick();
    stall = 6'b011111;
    tick();
    n_chk++;
    if (wb_wd !== 2'b00 || dut_bus() !== model_bus()) begin
      n_err++;
      $display("FAIL flush_over_hold: got %h want %h", dut_bus(), model_bus());
    end
    flush = 1'b0; stall = '0;
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    ex_wd = '0;
    while (m_cnt != CNT_MOD - 1 && guard < 4 * CNT_MOD) begin
      ex_valid = (CNT_MOD - 1 - m_cnt >= 2) ? 2'b11 : 2'b01;
      tick();
      guard++;
    end
    n_chk++;
    if (wb_retire_cnt !== CNT_W'(CNT_MOD - 1)) begin
      n_err++;
      $display("FAIL wrap_preload: got %0d want %0d", wb_retire_cnt, CNT_MOD - 1);
    end
    ex_valid = 2'b11;
    tick();
    n_chk++;
    if (wb_retire_cnt !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL wrap: got %0d want 1", wb_retire_cnt);
    end
  endtask

`ifdef WB_HILO_EN
  task automatic test_hilo();
    ex_whilo = 1'b1; ex_hi = 32'hA; ex_lo = 32'hB;
    tick();
    n_chk++;
    if ({wb_whilo, wb_hi, wb_lo} !== {1'b1, 32'hA, 32'hB}) begin
      n_err++;
      $display("FAIL hilo_load: got %b %h %h", wb_whilo, wb_hi, wb_lo);
    end
    flush = 1'b1;
    tick();
    n_chk++;
    if ({wb_whilo, wb_hi, wb_lo} !== '0) begin
      n_err++;
      $display("FAIL hilo_flush: got %b %h %h", wb_whilo, wb_hi, wb_lo);
    end
    flush = 1'b0;
    ex_whilo = 1'b0;
    tick();
    n_chk++;
    if ({wb_whilo, wb_hi, wb_lo} !== '0) begin
      n_err++;
      $display("FAIL hilo_off: got %b %h %h", wb_whilo, wb_hi, wb_lo);
    end
  endtask
`endif

  task automatic test_random();
    int sel;
    for (int k = 0; k < 400; k++) begin
      rand_inputs(3);
      rst   = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      flush = ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0;
      sel   = int'($urandom_range(0, 5));
      case (sel)
        3:       stall = 6'b011111;
        4:       stall = 6'b001111;
        5:       stall = STALL_W'($urandom);
        default: stall = '0;
      endcase
      tick();
      n_chk++;
      if (dut_bus() !== model_bus()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", k, dut_bus(), model_bus());
      end
    end
    rst = 1'b1; flush = 1'b0; stall = '0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = '0;
    ex_valid = '0; ex_wd = '0; ex_wreg = '0; ex_wdata = '0;
`ifdef WB_HILO_EN
    ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;
`endif
    model_bubble();
    m_cnt = 0;
    test_reset();
    test_plain_load();
    test_collision_r0();
    test_stall();
    test_bubble();
    test_flush();
    test_wrap();
`ifdef WB_HILO_EN
    test_hilo();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_pipe_reg.md
Name: wb_pipe_reg

Overview:
- Parametrised EX/MEM-to-WB pipeline register for a multi-issue core.
- Captures NUM_CH independent register-write channels per cycle.
- Honours pipeline stall and flush from the control unit.
- Suppresses writes to r0, resolves same-cycle write collisions, and keeps a retired-instruction counter.
- Sits between the last execute/memory stage and the register file write ports.

Parameters:
- DATA_W, 32, width of the write data per channel
- REG_AW, 5, register address width
- NUM_CH, 2, number of write channels (channel index order = program order; higher index = younger)
- STALL_W, 6, width of the stall vector from the control unit
- STAGE_IDX, 4, bit of the stall vector that belongs to this stage (1 <= STAGE_IDX < STALL_W)
- CNT_W, 32, width of the retire counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- stall  in  STALL_W  pipeline stall vector
- flush  in  1  exception/branch flush, loads a bubble
- ex_valid  in  NUM_CH  per-channel instruction-valid (retiring instruction present)
- ex_wd  in  NUM_CH  per-channel register-write enable
- ex_wreg  in  NUM_CH*REG_AW  packed destination addresses; channel i at [i*REG_AW +: REG_AW]
- ex_wdata  in  NUM_CH*DATA_W  packed write data; channel i at [i*DATA_W +: DATA_W]
- wb_wd  out  NUM_CH  registered write enables to the register file
- wb_wreg  out  NUM_CH*REG_AW  registered destination addresses
- wb_wdata  out  NUM_CH*DATA_W  registered write data
- wb_conflict  out  1  registered flag: a same-address collision was resolved in the loaded group
- wb_retire_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Reset (rst==0 at posedge): all outputs 0, including wb_retire_cnt. Reset overrides flush and stall.
- Per-cycle action, in priority order:
  1. flush==1: bubble.
  2. stall[STAGE_IDX-1]==1 and stall[STAGE_IDX]==0: bubble.
  3. stall[STAGE_IDX]==1: hold; all outputs keep their values and the counter does not change.
  4. Otherwise: load.
- Bubble: wb_wd, wb_wreg, wb_wdata and wb_conflict are set to 0. wb_retire_cnt is unchanged.
- Load, per channel i, computed in this order:
  - Effective write enable: we_i = ex_wd[i] && ex_wreg_i != 0. A write to r0 is dropped.
  - Collision: if we_i and some younger channel j > i has we_j with ex_wreg_j == ex_wreg_i, then we_i is cleared.
  - If we_i survives: wb_wd[i]=1, and wb_wreg/wb_wdata take channel i's ex_wreg/ex_wdata.
  - If we_i does not survive: wb_wd[i]=0 and that channel's wb_wreg/wb_wdata are 0.
  - wb_conflict = 1 if any clear was caused by a collision, else 0. A r0 drop does not set it.
  - wb_retire_cnt += popcount(ex_valid), modulo 2^CNT_W (wraps; no saturation).
  - ex_wd[i] with ex_valid[i]==0 is still honoured for the write; ex_valid affects only the counter.
- Latency: exactly 1 cycle from input to output when loading; no combinational input-to-output paths.

Optional Feature:
- Macro: WB_HILO_EN.
- Defined: adds inputs ex_whilo (1), ex_hi (DATA_W), ex_lo (DATA_W) and outputs wb_whilo, wb_hi, wb_lo.
  - Registered with the same reset/flush/bubble/hold rules.
  - If ex_whilo==0 on load, wb_hi and wb_lo are 0.
- Not defined: these ports do not exist and no HI/LO logic is present.

Decomposition:
- Shared defines header:
  - RstEnable = 1'b0
  - WriteEnable / WriteDisable
  - ZeroWord
  - ZeroReg
  - named stall-vector bit indices per pipeline stage
- Sub-module wb_chan_reg: one channel's wd/wreg/wdata register with load/bubble/hold inputs, instantiated NUM_CH times by generate.
- Collision resolution, conflict flag and retire counter stay in the top level.

Test Plan:
- Reset: drive rst=0 for 2 cycles with random inputs -> all outputs 0, wb_retire_cnt=0.
- Plain load:
  - Stimulus: ch0 wd=1, wreg=3, wdata=0xDEADBEEF; ch1 wd=1, wreg=7, wdata=0x12345678; ex_valid=2'b11; stall=0.
  - Expect next cycle: wb_wd=2'b11, both channels' addr/data as driven, wb_conflict=0, wb_retire_cnt=2.
- Collision and r0:
  - Stimulus: ch0 wreg=9, wdata=0x1; ch1 wreg=9, wdata=0x2; both wd=1 -> wb_wd=2'b10, ch1 data=0x2, ch0 fields=0, wb_conflict=1.
  - Then ch0 wreg=0, wd=1 -> wb_wd[0]=0, wb_conflict=0.
- Stall: stall=6'b011111 (STAGE_IDX=4) -> outputs held, counter frozen.
- Bubble: stall=6'b001111 -> all write outputs 0, counter unchanged.
- Flush and wrap:
  - Assert flush together with stall=6'b001111 -> bubble.
  - Preload the counter to 2^CNT_W-1, then load ex_valid=2'b11 -> wb_retire_cnt=1.
  - With WB_HILO_EN defined: ex_whilo=1, hi=0xA, lo=0xB -> wb_hi=0xA and wb_lo=0xB next cycle; a flush then clears both.
